// File: rtl/gb_joypad_pkg.sv
// Shared constants and helpers for the Game Boy P1/JOYP controller.
// The optional turbo feature is enabled by defining GB_JOYPAD_TURBO_EN.
package gb_joypad_pkg;

  // SNES frame bit positions (active-low in the raw frame).
  localparam int SNES_B      = 0;
  localparam int SNES_Y      = 1;
  localparam int SNES_SELECT = 2;
  localparam int SNES_START  = 3;
  localparam int SNES_UP     = 4;
  localparam int SNES_DOWN   = 5;
  localparam int SNES_LEFT   = 6;
  localparam int SNES_RIGHT  = 7;
  localparam int SNES_A      = 8;
  localparam int SNES_X      = 9;
  localparam int SNES_L      = 10;
  localparam int SNES_R      = 11;

  // GB button positions in the active-high pressed vector.
  localparam int GB_RIGHT  = 0;
  localparam int GB_LEFT   = 1;
  localparam int GB_UP     = 2;
  localparam int GB_DOWN   = 3;
  localparam int GB_A      = 4;
  localparam int GB_B      = 5;
  localparam int GB_SELECT = 6;
  localparam int GB_START  = 7;

  localparam logic [7:0] P1_RESET  = 8'hFF;
  localparam logic [1:0] P1_UNUSED = 2'b11;

  // Active-high GB buttons; packed so the vector matches pressed_dbg bit order.
  typedef struct packed {
    logic start;
    logic select;
    logic b;
    logic a;
    logic down;
    logic up;
    logic left;
    logic right;
  } gb_buttons_t;

  // Map a debounced active-low SNES frame onto GB buttons. L/R are ignored,
  // and opposing directions are passed through untouched.
  function automatic gb_buttons_t map_snes(input logic [15:0] frame);
    gb_buttons_t btn;
    btn.right  = ~frame[SNES_RIGHT];
    btn.left   = ~frame[SNES_LEFT];
    btn.up     = ~frame[SNES_UP];
    btn.down   = ~frame[SNES_DOWN];
    btn.a      = ~frame[SNES_A];
    btn.b      = ~frame[SNES_B];
    btn.select = ~frame[SNES_SELECT];
    btn.start  = ~frame[SNES_START];
    return btn;
  endfunction

  // Active-low P1[3:0] for a given select pair; a group contributes only
  // when its select line is low, and both selected AND together.
  function automatic logic [3:0] p1_nibble(input logic [1:0] sel,
                                           input gb_buttons_t btn);
    logic [3:0] dir_n;
    logic [3:0] act_n;
    dir_n = ~{btn.down, btn.up, btn.left, btn.right};
    act_n = ~{btn.start, btn.select, btn.b, btn.a};
    return (sel[0] ? 4'hF : dir_n) & (sel[1] ? 4'hF : act_n);
  endfunction

endpackage

// File: rtl/gb_joypad_ctrl_if.sv
// Bus bundle between the SNES sampler / CPU side and the joypad controller.
//
// Handshake: there is no back-pressure. snes_valid is a one-cycle strobe
// meaning snes_buttons holds a new complete frame on that clock edge; p1_wr
// is a one-cycle write strobe qualifying p1_wdata. Outputs are registered.
interface gb_joypad_ctrl_if;
  logic [15:0] snes_buttons;
  logic        snes_valid;
  logic        p1_wr;
  logic [7:0]  p1_wdata;
  logic [7:0]  p1_rdata;
  logic        joy_irq;
  logic [7:0]  pressed_dbg;

  modport master (
    output snes_buttons, snes_valid, p1_wr, p1_wdata,
    input  p1_rdata, joy_irq, pressed_dbg
  );

  modport slave (
    input  snes_buttons, snes_valid, p1_wr, p1_wdata,
    output p1_rdata, joy_irq, pressed_dbg
  );
endinterface

// File: rtl/gb_debounce.sv
// Vector debouncer: a new frame becomes stable only after it has been seen
// on DEBOUNCE_SAMPLES consecutive enabled samples.
module gb_debounce #(
  parameter int DEBOUNCE_SAMPLES = 2,
  parameter int W                = 16
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         en_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] stable_o
);

  localparam logic [3:0] THRESH = 4'(DEBOUNCE_SAMPLES - 1);

  logic [W-1:0] raw_q, raw_d;
  logic [W-1:0] stable_q, stable_d;
  logic [3:0]   match_cnt_q, match_cnt_d;
  logic [3:0]   cnt_inc;

  // Next-state: compare against the previous frame, count repeats, promote.
  always_comb begin
    raw_d       = raw_q;
    stable_d    = stable_q;
    match_cnt_d = match_cnt_q;
    cnt_inc     = (match_cnt_q == 4'hF) ? match_cnt_q : match_cnt_q + 4'd1;
    if (en_i) begin
      raw_d = din_i;
      if (DEBOUNCE_SAMPLES == 1) begin
        // No repeat needed: last captured frame becomes stable next frame.
        stable_d    = raw_q;
        match_cnt_d = 4'd0;
      end else if ((din_i == raw_q) && (raw_q != stable_q)) begin
        if (cnt_inc >= THRESH) begin
          stable_d    = raw_q;
          match_cnt_d = 4'd0;
        end else begin
          match_cnt_d = cnt_inc;
        end
      end else begin
        match_cnt_d = 4'd0;
      end
    end
  end

  // State registers; reset also drops any partially counted frame.
  always_ff @(posedge clock) begin
    if (!rst) begin
      raw_q       <= '1;
      stable_q    <= '1;
      match_cnt_q <= 4'd0;
    end else begin
      raw_q       <= raw_d;
      stable_q    <= stable_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/gb_joypad_ctrl.sv
// Game Boy P1/JOYP (0xFF00) controller: debounces SNES frames, maps them onto
// the GB 2x4 matrix, serves select writes / reads and raises the joypad IRQ.
// Optional turbo A/B on SNES X/Y is enabled by defining GB_JOYPAD_TURBO_EN.
module gb_joypad_ctrl
  import gb_joypad_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = 2
`ifdef GB_JOYPAD_TURBO_EN
  ,
  parameter int TURBO_SAMPLES    = 4
`endif
) (
  input logic             clock,
  input logic             rst,
  gb_joypad_ctrl_if.slave bus
);

  logic [15:0] stable;
  gb_buttons_t base_btn;
  gb_buttons_t eff_btn;
  logic [3:0]  nib;

  logic [1:0]  sel_q, sel_d;
  logic [3:0]  prev_nib_q;
  logic [7:0]  rdata_q, rdata_d;
  logic        irq_q, irq_d;
  logic [7:0]  pressed_q;

  gb_debounce #(
    .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES),
    .W                (16)
  ) u_debounce (
    .clock    (clock),
    .rst      (rst),
    .en_i     (bus.snes_valid),
    .din_i    (bus.snes_buttons),
    .stable_o (stable)
  );

  assign base_btn = map_snes(stable);

`ifdef GB_JOYPAD_TURBO_EN
  logic [7:0] turbo_cnt_q, turbo_cnt_d;
  logic       phase_q, phase_d;
  logic       turbo_on;

  // Turbo phase: flips every TURBO_SAMPLES frames; X/Y press A/B in phase 0.
  always_comb begin
    turbo_cnt_d = turbo_cnt_q;
    phase_d     = phase_q;
    if (bus.snes_valid) begin
      if (turbo_cnt_q == 8'(TURBO_SAMPLES - 1)) begin
        turbo_cnt_d = 8'd0;
        phase_d     = ~phase_q;
      end else begin
        turbo_cnt_d = turbo_cnt_q + 8'd1;
      end
    end
    turbo_on = ~phase_q;
    eff_btn   = base_btn;
    eff_btn.a = base_btn.a | (~stable[SNES_X] & turbo_on);
    eff_btn.b = base_btn.b | (~stable[SNES_Y] & turbo_on);
  end

  // Turbo phase registers.
  always_ff @(posedge clock) begin
    if (!rst) begin
      turbo_cnt_q <= 8'd0;
      phase_q     <= 1'b0;
    end else begin
      turbo_cnt_q <= turbo_cnt_d;
      phase_q     <= phase_d;
    end
  end
`else
  assign eff_btn = base_btn;
`endif

  // Select write, active-low nibble, read value and falling-edge detect.
  always_comb begin
    sel_d = sel_q;
    if (bus.p1_wr) begin
      sel_d = bus.p1_wdata[5:4];
    end
    nib     = p1_nibble(sel_q, eff_btn);
    rdata_d = {P1_UNUSED, sel_q, nib};
    irq_d   = |(prev_nib_q & ~nib);
  end

  // Registered read path, select register and interrupt pulse.
  always_ff @(posedge clock) begin
    if (!rst) begin
      sel_q      <= 2'b11;
      prev_nib_q <= 4'hF;
      rdata_q    <= P1_RESET;
      irq_q      <= 1'b0;
      pressed_q  <= 8'h00;
    end else begin
      sel_q      <= sel_d;
      prev_nib_q <= nib;
      rdata_q    <= rdata_d;
      irq_q      <= irq_d;
      pressed_q  <= eff_btn;
    end
  end

  assign bus.p1_rdata    = rdata_q;
  assign bus.joy_irq     = irq_q;
  assign bus.pressed_dbg = pressed_q;

endmodule

// File: tb/tb_gb_joypad_ctrl.sv
// Directed bench for gb_joypad_ctrl (default parameters). Expectations are
// hand-computed; the turbo section follows GB_JOYPAD_TURBO_EN.
module tb_gb_joypad_ctrl;

  logic clock = 1'b0;
  logic rst   = 1'b0;
  int   tests_run    = 0;
  int   tests_failed = 0;
  int   irq_seen     = 0;
  int   irq_base     = 0;

  // Clock / reset block
  always #5 clock = ~clock;

  gb_joypad_ctrl_if bus ();

  gb_joypad_ctrl dut (
    .clock (clock),
    .rst   (rst),
    .bus   (bus)
  );

  // Counts cycles with joy_irq high, so a single pulse adds exactly one.
  always @(negedge clock) begin
    if (bus.joy_irq === 1'b1) irq_seen++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Driver tasks: inputs change on the falling edge, DUT samples on rising.
  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b0;
    repeat (3) @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
  endtask

  task automatic send_frame(input logic [15:0] v);
    @(negedge clock);
    bus.snes_buttons = v;
    bus.snes_valid   = 1'b1;
    @(negedge clock);
    bus.snes_valid   = 1'b0;
  endtask

  task automatic cpu_write(input logic [7:0] d);
    @(negedge clock);
    bus.p1_wdata = d;
    bus.p1_wr    = 1'b1;
    @(negedge clock);
    bus.p1_wr    = 1'b0;
  endtask

  task automatic frame_and_write(input logic [15:0] v, input logic [7:0] d);
    @(negedge clock);
    bus.snes_buttons = v;
    bus.snes_valid   = 1'b1;
    bus.p1_wdata     = d;
    bus.p1_wr        = 1'b1;
    @(negedge clock);
    bus.snes_valid   = 1'b0;
    bus.p1_wr        = 1'b0;
  endtask

  logic exp_bit;
  logic prev_exp_bit;
  int   exp_falls;

  initial begin
    bus.snes_buttons = 16'hFFFF;
    bus.snes_valid   = 1'b0;
    bus.p1_wr        = 1'b0;
    bus.p1_wdata     = 8'h00;

    // Reset state
    do_reset();
    check("reset_rdata", 16'(bus.p1_rdata), 16'h00FF);
    check("reset_irq", 16'(bus.joy_irq), 16'h0000);
    check("reset_pressed", 16'(bus.pressed_dbg), 16'h0000);
    check("reset_irq_cnt", 16'(irq_seen), 16'h0000);

    // Glitch: non-repeating frames never reach stable
    cpu_write(8'h20);
    idle(1);
    check("dir_sel_rdata", 16'(bus.p1_rdata), 16'h00EF);
    irq_base = irq_seen;
    send_frame(16'hFF7F);
    send_frame(16'hFFFF);
    send_frame(16'hFF7F);
    idle(2);
    check("glitch_rdata", 16'(bus.p1_rdata), 16'h00EF);
    check("glitch_pressed", 16'(bus.pressed_dbg), 16'h0000);
    check("glitch_irq", 16'(irq_seen - irq_base), 16'h0000);

    // Right held two frames, direction group selected
    do_reset();
    cpu_write(8'h20);
    idle(1);
    irq_base = irq_seen;
    send_frame(16'hFF7F);
    idle(2);
    check("right_one_frame", 16'(bus.p1_rdata), 16'h00EF);
    send_frame(16'hFF7F);
    check("right_latency", 16'(bus.p1_rdata), 16'h00EF);
    @(negedge clock);
    check("right_rdata", 16'(bus.p1_rdata), 16'h00EE);
    check("right_pressed", 16'(bus.pressed_dbg), 16'h0001);
    idle(3);
    check("right_irq", 16'(irq_seen - irq_base), 16'h0001);

    // Release: rising edge must not interrupt
    send_frame(16'hFFFF);
    send_frame(16'hFFFF);
    idle(2);
    check("release_rdata", 16'(bus.p1_rdata), 16'h00EF);
    check("release_irq", 16'(irq_seen - irq_base), 16'h0001);

    // Opposing directions both reported
    irq_base = irq_seen;
    send_frame(16'hFF3F);
    send_frame(16'hFF3F);
    idle(2);
    check("lr_rdata", 16'(bus.p1_rdata), 16'h00EC);
    check("lr_pressed", 16'(bus.pressed_dbg), 16'h0003);
    check("lr_irq", 16'(irq_seen - irq_base), 16'h0001);
    send_frame(16'hFFFF);
    send_frame(16'hFFFF);

    // A held, nothing selected, then select action group
    cpu_write(8'h30);
    send_frame(16'hFEFF);
    send_frame(16'hFEFF);
    idle(2);
    check("a_unsel_rdata", 16'(bus.p1_rdata), 16'h00FF);
    check("a_pressed", 16'(bus.pressed_dbg), 16'h0010);
    irq_base = irq_seen;
    cpu_write(8'h10);
    check("a_sel_latency", 16'(bus.p1_rdata), 16'h00FF);
    @(negedge clock);
    check("a_sel_rdata", 16'(bus.p1_rdata), 16'h00DE);
    idle(2);
    check("a_sel_irq", 16'(irq_seen - irq_base), 16'h0001);

    // Both groups selected, Right + A, then release
    cpu_write(8'h00);
    send_frame(16'hFE7F);
    send_frame(16'hFE7F);
    idle(2);
    check("both_rdata", 16'(bus.p1_rdata), 16'h00CE);
    check("both_pressed", 16'(bus.pressed_dbg), 16'h0011);
    irq_base = irq_seen;
    send_frame(16'hFFFF);
    send_frame(16'hFFFF);
    idle(3);
    check("both_rel_rdata", 16'(bus.p1_rdata), 16'h00CF);
    check("both_rel_pressed", 16'(bus.pressed_dbg), 16'h0000);
    check("both_rel_irq", 16'(irq_seen - irq_base), 16'h0000);

    // Write and frame on the same edge
    cpu_write(8'h30);
    send_frame(16'hFEFF);
    irq_base = irq_seen;
    frame_and_write(16'hFEFF, 8'h10);
    @(negedge clock);
    check("simul_rdata", 16'(bus.p1_rdata), 16'h00DE);
    idle(2);
    check("simul_irq", 16'(irq_seen - irq_base), 16'h0001);

    // Reset mid-debounce discards the captured frame
    do_reset();
    cpu_write(8'h20);
    send_frame(16'hFF7F);
    do_reset();
    cpu_write(8'h20);
    send_frame(16'hFF7F);
    idle(2);
    check("midreset_rdata", 16'(bus.p1_rdata), 16'h00EF);

    // Turbo: X held, action group selected, k frames since reset
    do_reset();
    cpu_write(8'h10);
    idle(1);
    irq_base     = irq_seen;
    prev_exp_bit = 1'b1;
    exp_falls    = 0;
    for (int k = 1; k <= 16; k++) begin
      send_frame(16'hFDFF);
      idle(2);
`ifdef GB_JOYPAD_TURBO_EN
      exp_bit = ((k >= 2) && (((k / 4) % 2) == 0)) ? 1'b0 : 1'b1;
`else
      exp_bit = 1'b1;
`endif
      if (prev_exp_bit && !exp_bit) exp_falls++;
      prev_exp_bit = exp_bit;
      check($sformatf("turbo_bit0_k%0d", k), 16'(bus.p1_rdata[0]), 16'(exp_bit));
    end
    idle(2);
    check("turbo_irq", 16'(irq_seen - irq_base), 16'(exp_falls));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gb_joypad_ctrl.md
Name: gb_joypad_ctrl

Overview:
- Game Boy P1/JOYP (0xFF00) controller between the SNES controller sampler and the CPU bus.
- Captures each SNES button frame, debounces it and maps SNES buttons onto the GB 2x4 button matrix.
- Services CPU select writes and register reads.
- Raises the joypad interrupt request on any high-to-low transition of P1[3:0].

Parameters:
- DEBOUNCE_SAMPLES, 2: consecutive identical SNES frames required before the stable button state updates (range 1..15).
- TURBO_SAMPLES, 4: SNES frames per turbo phase; used only when GB_JOYPAD_TURBO_EN is defined (range 1..255).

Ports:
- clock  in  1  CPU clock (~4 MHz).
- rst  in  1  synchronous reset, active-low.
- snes_buttons  in  16  active-low button frame. Bits: 0 B, 1 Y, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right, 8 A, 9 X, 10 L, 11 R; 15:12 unused.
- snes_valid  in  1  one-cycle strobe: snes_buttons holds a new complete frame.
- p1_wr  in  1  CPU write strobe to P1.
- p1_wdata  in  8  write data; only bits 5:4 are used.
- p1_rdata  out  8  registered P1 read value.
- joy_irq  out  1  one-cycle interrupt request pulse (sets IF bit 4 upstream).
- pressed_dbg  out  8  debounced GB buttons, active-high, for LEDs. Bits: 0 Right, 1 Left, 2 Up, 3 Down, 4 A, 5 B, 6 Select, 7 Start.

Behaviour:
- Reset (rst==0 at a clock edge):
  - sel[1:0]=2'b11, raw=stable=16'hFFFF, match_cnt=0.
  - prev_nib=4'hF, p1_rdata=8'hFF, joy_irq=0, pressed_dbg=0, turbo phase=0.
  - Reset mid-frame discards any partial debounce count.
- Sampling, on snes_valid only:
  - If snes_buttons==raw and raw!=stable: match_cnt+1 (saturating).
  - Otherwise: match_cnt=0.
  - raw<=snes_buttons.
  - When the incremented match_cnt reaches DEBOUNCE_SAMPLES-1, stable<=raw and match_cnt=0 (in the same cycle).
  - DEBOUNCE_SAMPLES=1: stable follows raw on the frame after capture.
- Mapping: GB button pressed = corresponding stable bit ==0.
  - Dpad: Right/Left/Up/Down from SNES bits 7/6/4/5.
  - A from bit 8, B from bit 0, Select from 2, Start from 3.
  - L and R are ignored.
  - Opposing directions pressed together are both reported.
- Select register: on p1_wr, sel<=p1_wdata[5:4]. sel[0] = P14 (direction group, low=selected); sel[1] = P15 (action group).
- Nibble (computed combinationally every cycle, active-low):
  - dir_n = ~{Down,Up,Left,Right}.
  - act_n = ~{Start,Select,B,A}.
  - nib = (sel[0]?4'hF:dir_n) & (sel[1]?4'hF:act_n).
  - Both groups selected: AND of the two groups. Neither selected: 4'hF.
- Read path: p1_rdata <= {2'b11, sel, nib} each cycle; one-cycle latency from any state change. pressed_dbg is registered the same way.
- Interrupt:
  - joy_irq <= |(prev_nib & ~nib); prev_nib <= nib every cycle.
  - Pulse width is exactly one cycle per edge event; back-to-back events give back-to-back pulses.
  - Select-write-induced falling edges also fire.
  - Rising edges never fire.
- Simultaneous p1_wr and snes_valid: both take effect in the same edge; nib in the next cycle uses the new sel and the new stable.

Optional Feature:
- Macro: GB_JOYPAD_TURBO_EN.
- Defined:
  - SNES X (bit 9) acts as turbo A and SNES Y (bit 1) as turbo B.
  - An 8-bit phase counter advances on snes_valid; phase toggles every TURBO_SAMPLES frames.
  - Effective A = A | (X & phase==0); effective B = B | (Y & phase==0).
  - Phase counter cleared by reset.
- Undefined: X and Y are ignored; no counter is present.

Decomposition:
- gb_joypad_pkg:
  - SNES bit index constants, GB matrix bit index constants.
  - P1_RESET=8'hFF, P1_UNUSED=2'b11.
- Sub-module gb_debounce: 16-bit vector debounce (raw/stable/match_cnt) with DEBOUNCE_SAMPLES parameter, clocked by snes_valid enable. Top handles mapping, select register, read path and interrupt.

Test Plan:
- Reset held 3 cycles, then released, no input -> p1_rdata=8'hFF, joy_irq=0, pressed_dbg=0.
- Write p1_wdata=8'h20 (direction selected); two frames of 16'hFF7F (Right held), DEBOUNCE_SAMPLES=2 -> after the second frame stable updates; next cycle p1_rdata=8'hEE; exactly one joy_irq pulse.
- Glitch: frames FF7F, FFFF, FF7F -> stable unchanged, p1_rdata stays 8'hEF, no joy_irq.
- A held (16'hFEFF stable) with sel=2'b11, then write 8'h10 -> p1_rdata=8'hDE one cycle later; one joy_irq pulse caused by the select change.
- sel=2'b00, Right and A held -> nib=4'hE; release both -> 4'hF, no joy_irq on release.
- With GB_JOYPAD_TURBO_EN, TURBO_SAMPLES=4, X held, action group selected -> p1_rdata[0] alternates 0/1 every 4 frames; joy_irq at each 1->0 transition. Without the macro -> bit stays 1.
